// File: rtl/tetris_pkg.sv
// Shared types for the Tetris button front end.
// Button indices follow the held_o bit order {start, rotate, right, left}.
package tetris_pkg;

  localparam int NUM_BTNS = 4;

  typedef enum logic [1:0] {
    BTN_LEFT   = 2'd0,
    BTN_RIGHT  = 2'd1,
    BTN_ROTATE = 2'd2,
    BTN_START  = 2'd3
  } btn_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } das_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, counting debouncer, rising-edge press.
// press_o is high for the cycle right after the stable level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_d, sync_q;
  logic          level_d, level_q;
  logic          press_d, press_q;
  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris button front end: debounced single-cycle commands, DAS/ARR on left/right.
// Auto-repeat is built only when TETRIS_AUTOREPEAT_EN is defined.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int DAS_DELAY_CYCLES = 8000000,
  parameter int ARR_CYCLES       = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_start,
  output logic       left_o,
  output logic       right_o,
  output logic       rotate_o,
  output logic       start_o,
  output logic [3:0] held_o
);

  if (DEBOUNCE_CYCLES < 1 || DAS_DELAY_CYCLES < 1 || ARR_CYCLES < 1) begin : g_bad_cfg
    $error("tetris_input_ctrl: timing parameters must be >= 1");
  end

  logic [NUM_BTNS-1:0] btn;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] press;

  assign btn = {btn_start, btn_rotate, btn_right, btn_left};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  logic both_press;
  logic [1:0] fire;

  assign both_press = press[BTN_LEFT] & press[BTN_RIGHT];

`ifdef TETRIS_AUTOREPEAT_EN
  localparam int TMAX = (DAS_DELAY_CYCLES > ARR_CYCLES) ?
                        DAS_DELAY_CYCLES : ARR_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DAS_LAST = TW'(DAS_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] ARR_LAST = TW'(ARR_CYCLES - 1);

  das_state_t    st_d  [2];
  das_state_t    st_q  [2];
  logic [TW-1:0] tmr_d [2];
  logic [TW-1:0] tmr_q [2];
  logic          conflict;

  // Both directions held: timers freeze, only fresh presses may fire.
  assign conflict = level[BTN_LEFT] & level[BTN_RIGHT];

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      st_d[d]  = st_q[d];
      tmr_d[d] = tmr_q[d];
      fire[d]  = 1'b0;
      if (!level[d]) begin
        st_d[d]  = IDLE;
        tmr_d[d] = '0;
      end else begin
        unique case (st_q[d])
          IDLE: begin
            if (press[d]) begin
              fire[d]  = 1'b1;
              st_d[d]  = DELAY;
              tmr_d[d] = '0;
            end
          end
          DELAY: begin
            if (!conflict) begin
              if (tmr_q[d] == DAS_LAST) begin
                fire[d]  = 1'b1;
                st_d[d]  = REPEAT;
                tmr_d[d] = '0;
              end else begin
                tmr_d[d] = tmr_q[d] + TW'(1);
              end
            end
          end
          REPEAT: begin
            if (!conflict) begin
              if (tmr_q[d] == ARR_LAST) begin
                fire[d]  = 1'b1;
                tmr_d[d] = '0;
              end else begin
                tmr_d[d] = tmr_q[d] + TW'(1);
              end
            end
          end
          default: begin
            st_d[d]  = IDLE;
            tmr_d[d] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        st_q[d]  <= IDLE;
        tmr_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        st_q[d]  <= st_d[d];
        tmr_q[d] <= tmr_d[d];
      end
    end
  end
`else
  assign fire = press[1:0];
`endif

  logic [NUM_BTNS-1:0] cmd_d, cmd_q;

  always_comb begin
    cmd_d             = '0;
    cmd_d[BTN_LEFT]   = fire[0];
    cmd_d[BTN_RIGHT]  = fire[1] & ~both_press;
    cmd_d[BTN_ROTATE] = press[BTN_ROTATE];
    cmd_d[BTN_START]  = press[BTN_START];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  assign left_o   = cmd_q[BTN_LEFT];
  assign right_o  = cmd_q[BTN_RIGHT];
  assign rotate_o = cmd_q[BTN_ROTATE];
  assign start_o  = cmd_q[BTN_START];
  assign held_o   = level;

endmodule
